// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - fetch PC, one-at-a-time fetch handshake, static predecode, instruction queue
module instruction_fetcher #(
    parameter int          IQ_DEPTH_LOG = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] roll_back_pc,
    output logic        mc_fetch_start,
    output logic [31:0] mc_pc,
    input  logic        mc_finish_fetch,
    input  logic [31:0] mc_instruction,
    input  logic [31:0] mc_instruction_pc,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    input  logic        iq_pop,
    output logic        iq_full
);

    localparam int                  DEPTH   = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0]   CNT_MAX = (IQ_DEPTH_LOG + 1)'(DEPTH);
    localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE = (IQ_DEPTH_LOG + 1)'(1);
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = IQ_DEPTH_LOG'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    start_q, start_d;
    logic [IQ_DEPTH_LOG-1:0] head_q, head_d;
    logic [IQ_DEPTH_LOG-1:0] tail_q, tail_d;
    logic [IQ_DEPTH_LOG:0]   count_q, count_d;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        pred_mem [DEPTH];

    logic        push, pop, flush;
    logic [31:0] imm_j, imm_b, next_pc;
    logic        pred_taken;

    // Static prediction: JAL always taken, backward conditional branches taken.
    always_comb begin
        imm_j      = {{11{mc_instruction[31]}}, mc_instruction[31], mc_instruction[19:12],
                      mc_instruction[20], mc_instruction[30:21], 1'b0};
        imm_b      = {{19{mc_instruction[31]}}, mc_instruction[31], mc_instruction[7],
                      mc_instruction[30:25], mc_instruction[11:8], 1'b0};
        next_pc    = pc_q + 32'd4;
        pred_taken = 1'b0;
        if (mc_instruction[6:0] == 7'b1101111) begin
            next_pc    = pc_q + imm_j;
            pred_taken = 1'b1;
        end else if (mc_instruction[6:0] == 7'b1100011 && imm_b[31]) begin
            next_pc    = pc_q + imm_b;
            pred_taken = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        start_d = start_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (rdy_in) begin
            if (roll_back) begin
                flush   = 1'b1;
                pc_d    = roll_back_pc;
                start_d = 1'b0;
                state_d = S_IDLE;
            end else begin
                pop = iq_pop && (count_q != '0);
                case (state_q)
                    S_IDLE: begin
                        if (count_q < CNT_MAX) begin
                            start_d = 1'b1;
                            state_d = S_WAIT;
                        end else begin
                            start_d = 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (mc_finish_fetch) begin
                            start_d = 1'b0;
                            state_d = S_GAP;
                            // A word tagged with a stale PC is dropped and the same PC refetched.
                            if (mc_instruction_pc == pc_q) begin
                                push = 1'b1;
                                pc_d = next_pc;
                            end
                        end
                    end
                    S_GAP: begin
                        start_d = 1'b0;
                        state_d = S_IDLE;
                    end
                    default: begin
                        start_d = 1'b0;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)
                head_d = head_q + PTR_ONE;
            if (push)
                tail_d = tail_q + PTR_ONE;
            if (push && !pop)
                count_d = count_q + CNT_ONE;
            else if (pop && !push)
                count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            start_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            start_q <= start_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail_q] <= mc_instruction;
            pc_mem[tail_q]   <= pc_q;
            pred_mem[tail_q] <= pred_taken;
        end
    end

    assign mc_fetch_start = start_q;
    assign mc_pc          = pc_q;
    assign iq_valid       = (count_q != '0);
    assign iq_full        = (count_q == CNT_MAX);
    assign iq_inst        = iq_valid ? inst_mem[head_q] : 32'h0;
    assign iq_pc          = iq_valid ? pc_mem[head_q]   : 32'h0;
    assign iq_pred_taken  = iq_valid ? pred_mem[head_q] : 1'b0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - randomized bench for instruction_fetcher against a queue-based reference model
module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, roll_back, iq_pop;
    logic [31:0] roll_back_pc;
    logic        mc_fetch_start, mc_finish_fetch;
    logic [31:0] mc_pc, mc_instruction, mc_instruction_pc;
    logic        iq_valid, iq_pred_taken, iq_full;
    logic [31:0] iq_inst, iq_pc;

    always #5 clk_in = ~clk_in;

    instruction_fetcher #(.IQ_DEPTH_LOG(4), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .roll_back(roll_back), .roll_back_pc(roll_back_pc),
        .mc_fetch_start(mc_fetch_start), .mc_pc(mc_pc),
        .mc_finish_fetch(mc_finish_fetch), .mc_instruction(mc_instruction),
        .mc_instruction_pc(mc_instruction_pc),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_pred_taken(iq_pred_taken), .iq_pop(iq_pop), .iq_full(iq_full)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        q_m[$];
    logic [31:0] pc_m;
    logic        start_m;
    int          phase_m;
    logic        pushed_m;
    logic [31:0] pushed_pc_m;

    logic [31:0] mem [256];
    int          lat, ctl_cnt, wrong_pct;
    bit          ctl_done, rand_lat;
    int          n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", tag);
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        int s;
        s = int'(v) <<< (32 - bits);
        s = s >>> (32 - bits);
        return 32'(s);
    endfunction

    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output logic [31:0] npc, output logic taken);
        logic [31:0] off;
        npc   = pc + 32'd4;
        taken = 1'b0;
        if (inst[6:0] == 7'h6F) begin
            off   = sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
            npc   = pc + off;
            taken = 1'b1;
        end else if (inst[6:0] == 7'h63) begin
            off = sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
            if ($signed(off) < 0) begin
                npc   = pc + off;
                taken = 1'b1;
            end
        end
    endfunction

    // Reference: applies the inputs present before the edge; phase 0 idle, 1 awaiting word, 2 gap.
    task automatic model_step();
        int          sz;
        bit          do_push;
        ent_t        e;
        logic [31:0] npc;
        logic        tk;
        pushed_m = 1'b0;
        do_push  = 1'b0;
        if (!rst_in) begin
            q_m.delete();
            pc_m = 32'h0; start_m = 1'b0; phase_m = 0;
        end else if (!rdy_in) begin
        end else if (roll_back) begin
            q_m.delete();
            pc_m = roll_back_pc; start_m = 1'b0; phase_m = 0;
        end else begin
            sz = q_m.size();
            if (phase_m == 0) begin
                if (sz < 16) begin start_m = 1'b1; phase_m = 1; end
            end else if (phase_m == 1) begin
                if (mc_finish_fetch) begin
                    start_m = 1'b0; phase_m = 2;
                    if (mc_instruction_pc == pc_m) begin
                        predict(mc_instruction, pc_m, npc, tk);
                        e.inst = mc_instruction; e.pc = pc_m; e.pred = tk;
                        do_push = 1'b1;
                        pushed_m = 1'b1; pushed_pc_m = pc_m;
                        pc_m = npc;
                    end
                end
            end else begin
                phase_m = 0;
            end
            if (iq_pop && sz > 0) void'(q_m.pop_front());
            if (do_push) q_m.push_back(e);
        end
    endtask

    task automatic compare_all();
        check_eq("start", {31'b0, mc_fetch_start}, {31'b0, start_m});
        check_eq("mc_pc", mc_pc, pc_m);
        check_eq("iq_valid", {31'b0, iq_valid}, {31'b0, q_m.size() != 0});
        check_eq("iq_full", {31'b0, iq_full}, {31'b0, q_m.size() == 16});
        if (q_m.size() != 0) begin
            check_eq("iq_inst", iq_inst, q_m[0].inst);
            check_eq("iq_pc", iq_pc, q_m[0].pc);
            check_eq("iq_pred", {31'b0, iq_pred_taken}, {31'b0, q_m[0].pred});
        end
    endtask

    // Memory-controller stand-in: answers after lat cycles of an outstanding request.
    task automatic drive_ctl();
        logic [31:0] p;
        mc_finish_fetch = 1'b0;
        if (!mc_fetch_start || !rst_in) begin
            ctl_cnt = 0; ctl_done = 1'b0;
        end else if (rdy_in && !ctl_done) begin
            if (ctl_cnt == 0 && rand_lat) lat = $urandom_range(1, 6);
            ctl_cnt++;
            if (ctl_cnt >= lat) begin
                p = mc_pc;
                mc_finish_fetch   = 1'b1;
                ctl_done          = 1'b1;
                mc_instruction    = mem[p[9:2]];
                mc_instruction_pc = ($urandom_range(99) < wrong_pct) ? p + 32'd4 : p;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic run_until_push(input logic [31:0] want, input bit any_pc, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            iq_pop = 1'b0; roll_back = 1'b0;
            drive_ctl();
            cycle();
            if (pushed_m && (any_pc || pushed_pc_m == want)) hit = 1'b1;
        end
        if (!hit) timeout(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_start"}, {31'b0, mc_fetch_start}, 32'h0);
        check_eq({tag, "_mc_pc"}, mc_pc, 32'h0);
        check_eq({tag, "_valid"}, {31'b0, iq_valid}, 32'h0);
        check_eq({tag, "_inst"}, iq_inst, 32'h0);
        check_eq({tag, "_pc"}, iq_pc, 32'h0);
        check_eq({tag, "_pred"}, {31'b0, iq_pred_taken}, 32'h0);
        check_eq({tag, "_full"}, {31'b0, iq_full}, 32'h0);
    endtask

    initial begin
        bit          done;
        logic [31:0] r;
        int          k;

        rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; roll_back_pc = 32'h0; iq_pop = 1'b0;
        mc_finish_fetch = 1'b0; mc_instruction = 32'h0; mc_instruction_pc = 32'h0;
        lat = 5; rand_lat = 1'b0; wrong_pct = 0; ctl_cnt = 0; ctl_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
        mem[32'h10 >> 2]  = 32'h0080006F;
        mem[32'h20 >> 2]  = 32'hFE000EE3;
        mem[32'h100 >> 2] = 32'h00000463;

        cycle();
        cycle();
        check_reset_values("reset");
        rst_in = 1'b1;

        // NOP stream, then JAL at 0x10 and backward BEQ at 0x20
        run_until_push(32'h10, 1'b0, "jal_push");
        check_eq("jal_next_pc", mc_pc, 32'h18);
        run_until_push(32'h20, 1'b0, "beq_back_push");
        check_eq("beq_back_next_pc", mc_pc, 32'h1C);

        // fill the queue with no pops
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            iq_pop = 1'b0; drive_ctl(); cycle();
            if (q_m.size() == 16) done = 1'b1;
        end
        if (!done) timeout("fill");
        check_eq("full_flag", {31'b0, iq_full}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            iq_pop = 1'b0; drive_ctl(); cycle();
        end
        check_eq("full_no_start", {31'b0, mc_fetch_start}, 32'h0);

        iq_pop = 1'b1; drive_ctl(); cycle();
        run_until_push(32'h0, 1'b1, "refill");
        check_eq("refull", {31'b0, iq_full}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            iq_pop = 1'b1; drive_ctl(); cycle();
        end
        iq_pop = 1'b0;
        check_eq("jal_head_pc", iq_pc, 32'h10);
        check_eq("jal_head_pred", {31'b0, iq_pred_taken}, 32'h1);

        // pop in step with every finish pulse, then drain continuously
        for (int i = 0; i < 60; i++) begin
            drive_ctl(); iq_pop = mc_finish_fetch; cycle();
        end
        for (int i = 0; i < 150; i++) begin
            drive_ctl(); iq_pop = 1'b1; cycle();
        end

        // roll back with count 5 on the same cycle as a finish pulse
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            roll_back = 1'b0;
            iq_pop = (q_m.size() > 5) && (i % 4 != 3);
            drive_ctl();
            if (mc_finish_fetch && q_m.size() == 5 && !iq_pop) begin
                roll_back = 1'b1; roll_back_pc = 32'h100; done = 1'b1;
            end
            cycle();
        end
        roll_back = 1'b0; iq_pop = 1'b0;
        if (!done) timeout("rollback_setup");
        check_eq("rb_valid", {31'b0, iq_valid}, 32'h0);
        check_eq("rb_start", {31'b0, mc_fetch_start}, 32'h0);
        check_eq("rb_mc_pc", mc_pc, 32'h100);
        drive_ctl(); cycle();
        check_eq("rb_restart", {31'b0, mc_fetch_start}, 32'h1);
        run_until_push(32'h100, 1'b0, "beq_fwd_push");
        check_eq("beq_fwd_next_pc", mc_pc, 32'h104);
        check_eq("beq_fwd_head_pc", iq_pc, 32'h100);
        check_eq("beq_fwd_pred", {31'b0, iq_pred_taken}, 32'h0);

        // pause for 3 cycles while a request is outstanding
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (mc_fetch_start) done = 1'b1;
            else begin drive_ctl(); cycle(); end
        end
        if (!done) timeout("pause_setup");
        for (int i = 0; i < 3; i++) begin
            rdy_in = 1'b0; iq_pop = 1'b1; drive_ctl(); cycle();
        end
        rdy_in = 1'b1; iq_pop = 1'b0;

        // asynchronous reset mid-request
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (mc_fetch_start && q_m.size() != 0) done = 1'b1;
            else begin drive_ctl(); cycle(); end
        end
        if (!done) timeout("areset_setup");
        #2;
        rst_in = 1'b0;
        mc_finish_fetch = 1'b0;
        #1;
        check_reset_values("areset");
        cycle();
        cycle();
        rst_in = 1'b1;

        // randomized traffic
        rand_lat = 1'b1; wrong_pct = 10;
        for (int i = 0; i < 256; i++) begin
            r = $urandom();
            k = $urandom_range(99);
            if (k < 55)      mem[i] = {r[31:7], 7'h13};
            else if (k < 70) mem[i] = {r[31:7], 7'h6F};
            else if (k < 92) mem[i] = {r[31:7], 7'h63};
            else             mem[i] = {r[31:7], 7'h67};
        end
        for (int i = 0; i < 2500; i++) begin
            rdy_in    = ($urandom_range(99) >= 10);
            iq_pop    = ($urandom_range(99) < 45);
            roll_back = ($urandom_range(99) < 2);
            roll_back_pc = {$urandom_range(255), 2'b00};
            drive_ctl();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
